// File: rtl/uart_tx_arbiter_if.sv
// Signal bundle between the two TX byte FIFOs, the arbiter and the UART serializer.
`timescale 1ns/1ps
interface uart_tx_arbiter_if #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
);
    localparam int CW = $clog2(MAX_BURST + 1);

    // Handshakes: fi_rd_en pops one word and is only raised while !fi_empty;
    // tx_start is a one-cycle pulse issued only while tx_busy = 0, tx_data is
    // held from tx_start until the matching one-cycle tx_done pulse.
    logic             en;
    logic [1:0]       ch_en;
    logic             f0_empty;
    logic [WIDTH-1:0] f0_data;
    logic             f0_rd_en;
    logic             f1_empty;
    logic [WIDTH-1:0] f1_data;
    logic             f1_rd_en;
    logic             tx_busy;
    logic             tx_done;
    logic             tx_start;
    logic [WIDTH-1:0] tx_data;
    logic [1:0]       grant;
    logic             active;
    logic [CW-1:0]    burst_cnt;
    logic [2:0]       state;

    modport master (
        input  en, ch_en, f0_empty, f0_data, f1_empty, f1_data, tx_busy, tx_done,
        output f0_rd_en, f1_rd_en, tx_start, tx_data, grant, active, burst_cnt, state
    );

    modport slave (
        output en, ch_en, f0_empty, f0_data, f1_empty, f1_data, tx_busy, tx_done,
        input  f0_rd_en, f1_rd_en, tx_start, tx_data, grant, active, burst_cnt, state
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between two byte FIFOs,
// with a per-grant burst limit and start/done sequencing.
`timescale 1ns/1ps
module uart_tx_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input logic              clk,
    input logic              rst,
    uart_tx_arbiter_if.master bus
);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_LOAD   = 3'd2,
        S_SEND   = 3'd3,
        S_WAIT   = 3'd4
    } state_t;

    state_t           state, state_n;
    logic [1:0]       grant, grant_n;
    logic             ptr, ptr_n;
    logic [CW-1:0]    burst_cnt, burst_n;
    logic [WIDTH-1:0] tx_data, tx_data_n;
    logic [CW-1:0]    cnt_inc;
    logic             elig0, elig1, granted_elig;

    assign elig0        = bus.en && bus.ch_en[0] && !bus.f0_empty;
    assign elig1        = bus.en && bus.ch_en[1] && !bus.f1_empty;
    assign granted_elig = grant[1] ? elig1 : elig0;
    assign cnt_inc      = burst_cnt + CW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            grant     <= 2'b00;
            ptr       <= 1'b0;
            burst_cnt <= '0;
            tx_data   <= '0;
        end else begin
            state     <= state_n;
            grant     <= grant_n;
            ptr       <= ptr_n;
            burst_cnt <= burst_n;
            tx_data   <= tx_data_n;
        end
    end

    always_comb begin
        state_n   = state;
        grant_n   = grant;
        ptr_n     = ptr;
        burst_n   = burst_cnt;
        tx_data_n = tx_data;
        case (state)
            S_IDLE: begin
                if (elig0 || elig1) begin
                    state_n = S_SETTLE;
                    burst_n = '0;
                    if (elig0 && elig1) grant_n = ptr ? 2'b10 : 2'b01;
                    else                grant_n = elig0 ? 2'b01 : 2'b10;
                end
            end
            S_SETTLE: state_n = S_LOAD;
            S_LOAD: begin
                tx_data_n = grant[1] ? bus.f1_data : bus.f0_data;
                state_n   = S_SEND;
            end
            S_SEND: begin
                if (!bus.tx_busy) state_n = S_WAIT;
            end
            S_WAIT: begin
                if (bus.tx_done) begin
                    burst_n = cnt_inc;
                    // The count never passes MAX_BURST because the grant ends there.
                    if (cnt_inc < CW'(MAX_BURST) && granted_elig) begin
                        state_n = S_SETTLE;
                    end else begin
                        state_n = S_IDLE;
                        grant_n = 2'b00;
                        ptr_n   = !grant[1];
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Strobes are masked by rst so nothing pops or starts in a reset cycle.
    always_comb begin
        bus.f0_rd_en = 1'b0;
        bus.f1_rd_en = 1'b0;
        bus.tx_start = 1'b0;
        bus.active   = (state != S_IDLE);
        if (!rst) begin
            bus.f0_rd_en = (state == S_LOAD) && grant[0];
            bus.f1_rd_en = (state == S_LOAD) && grant[1];
            bus.tx_start = (state == S_SEND) && !bus.tx_busy;
        end
    end

    assign bus.grant     = grant;
    assign bus.burst_cnt = burst_cnt;
    assign bus.tx_data   = tx_data;
    assign bus.state     = state;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: FIFO and transmitter models, hand sequences,
// a vector table and randomized runs checked against a round-robin model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;
    localparam int DEPTH     = 1024;

    typedef struct {
        logic       en;
        logic [1:0] ch_en;
        int         n0;
        int         n1;
        logic [1:0] exp_first;
        int         exp_pops0;
        int         exp_pops1;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) bus ();
    uart_tx_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    int checks = 0;
    int errors = 0;
    int rd0 = 0, rd1 = 0, wr0 = 0, wr1 = 0;
    logic [WIDTH-1:0] mem0[DEPTH];
    logic [WIDTH-1:0] mem1[DEPTH];
    logic [WIDTH:0]   exp_q[$];
    int pops0 = 0, pops1 = 0;
    logic [1:0] first_grant = 2'b00;
    bit sb_on = 0, auto_tx = 0, hold_busy = 0, man_done = 0;
    bit resp_busy = 0, resp_done = 0, in_flight = 0;
    int resp_left = 0;
    logic [WIDTH-1:0] held_data = '0;
    int model_ptr = 0;

    // FIFO model: registered read data lags a pop by one cycle.
    assign bus.f0_empty = (rd0 == wr0);
    assign bus.f1_empty = (rd1 == wr1);
    always @(posedge clk) begin
        bus.f0_data <= mem0[rd0 % DEPTH];
        bus.f1_data <= mem1[rd1 % DEPTH];
        if (bus.f0_rd_en) rd0 <= rd0 + 1;
        if (bus.f1_rd_en) rd1 <= rd1 + 1;
    end

    assign bus.tx_busy = resp_busy | hold_busy;
    assign bus.tx_done = resp_done | man_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push0(input logic [WIDTH-1:0] d);
        mem0[wr0 % DEPTH] = d;
        wr0++;
    endtask

    task automatic push1(input logic [WIDTH-1:0] d);
        mem1[wr1 % DEPTH] = d;
        wr1++;
    endtask

    task automatic run_monitor();
        forever begin
            @(negedge clk);
            if (rst) begin
                in_flight = 0;
            end else begin
                checks++;
                if ((bus.f0_rd_en && bus.f0_empty) || (bus.f1_rd_en && bus.f1_empty) ||
                    (bus.f0_rd_en && bus.f1_rd_en) || (bus.grant == 2'b11)) begin
                    errors++;
                    $display("FAIL invariant: rd_en=%b%b empty=%b%b grant=%b required legal",
                             bus.f1_rd_en, bus.f0_rd_en, bus.f1_empty, bus.f0_empty, bus.grant);
                end
                if (bus.f0_rd_en) pops0++;
                if (bus.f1_rd_en) pops1++;
                if (bus.grant != 2'b00 && first_grant == 2'b00) first_grant = bus.grant;
                if (bus.tx_done && in_flight) begin
                    chk("tx_data_hold", bus.tx_data, held_data);
                    in_flight = 0;
                end
                if (bus.tx_start) begin
                    held_data = bus.tx_data;
                    in_flight = 1;
                    if (sb_on) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL sb_extra: got ch%0d %0h required none", bus.grant[1], bus.tx_data);
                        end else begin
                            logic [WIDTH:0] e;
                            e = exp_q.pop_front();
                            if ({bus.grant[1], bus.tx_data} !== e) begin
                                errors++;
                                $display("FAIL sb_byte: got ch%0d %0h required ch%0d %0h",
                                         bus.grant[1], bus.tx_data, e[WIDTH], e[WIDTH-1:0]);
                            end
                        end
                    end
                end
            end
        end
    endtask

    // Transmitter model: busy for a random number of cycles, then a done pulse.
    task automatic run_responder();
        bit s;
        forever begin
            @(negedge clk);
            s = bus.tx_start && auto_tx;
            @(posedge clk);
            #1;
            resp_done = 0;
            if (rst) begin
                resp_busy = 0;
                resp_left = 0;
            end else if (s) begin
                resp_busy = 1;
                resp_left = $urandom_range(1, 6);
            end else if (resp_busy) begin
                resp_left--;
                if (resp_left == 0) begin
                    resp_busy = 0;
                    resp_done = 1;
                end
            end
        end
    endtask

    task automatic wait_idle(input string name);
        int quiet = 0;
        for (int i = 0; i < 3000 && quiet < 3; i++) begin
            @(negedge clk);
            if (!bus.active && !bus.tx_busy) quiet++;
            else quiet = 0;
        end
        chk(name, quiet, 3);
    endtask

    task automatic wait_start(input string name);
        bit seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.tx_start) begin
                seen = 1;
                break;
            end
        end
        chk(name, seen, 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_grant"}, bus.grant, 0);
        chk({tag, "_active"}, bus.active, 0);
        chk({tag, "_tx_start"}, bus.tx_start, 0);
        chk({tag, "_tx_data"}, bus.tx_data, 0);
        chk({tag, "_burst_cnt"}, bus.burst_cnt, 0);
        chk({tag, "_rd_en"}, {bus.f1_rd_en, bus.f0_rd_en}, 0);
    endtask

    // Reference: whole bursts of up to MAX_BURST, rr pointer flips after each grant.
    task automatic build_expected(input logic e, input logic [1:0] m, input int n0, input int n1);
        int r0, r1, i0, i1, ch, k;
        r0 = (e && m[0]) ? n0 : 0;
        r1 = (e && m[1]) ? n1 : 0;
        i0 = 0;
        i1 = 0;
        while (r0 > 0 || r1 > 0) begin
            if (r0 > 0 && r1 > 0) ch = model_ptr;
            else                  ch = (r0 > 0) ? 0 : 1;
            k = (ch == 0) ? r0 : r1;
            if (k > MAX_BURST) k = MAX_BURST;
            for (int j = 0; j < k; j++) begin
                if (ch == 0) begin
                    exp_q.push_back({1'b0, mem0[(rd0 + i0) % DEPTH]});
                    i0++;
                end else begin
                    exp_q.push_back({1'b1, mem1[(rd1 + i1) % DEPTH]});
                    i1++;
                end
            end
            if (ch == 0) r0 -= k;
            else         r1 -= k;
            model_ptr = 1 - ch;
        end
    endtask

    task automatic run_vector(input logic e, input logic [1:0] m, input int n0, input int n1);
        bus.en = 0;
        bus.ch_en = m;
        for (int i = 0; i < n0; i++) push0(WIDTH'($urandom));
        for (int i = 0; i < n1; i++) push1(WIDTH'($urandom));
        exp_q.delete();
        build_expected(e, m, n0, n1);
        pops0 = 0;
        pops1 = 0;
        first_grant = 2'b00;
        sb_on = 1;
        step();
        bus.en = e;
        wait_idle("vec_idle");
        chk("sb_drained", exp_q.size(), 0);
        sb_on = 0;
        bus.en = 0;
        step();
        wr0 = rd0;
        wr1 = rd1;
    endtask

    vec_t vt[6];

    initial begin
        int r0_save, r1_save, bad, m_rand, n0_rand, n1_rand;
        bit seen;
        bus.en = 0;
        bus.ch_en = 2'b00;
        fork
            run_monitor();
            run_responder();
        join_none

        // Reset values
        repeat (3) step();
        @(negedge clk);
        chk_reset_outputs("reset");
        step();
        rst = 0;

        // Single byte latency from IDLE
        push0(8'hA5);
        bus.ch_en = 2'b11;
        step();
        bus.en = 1;
        @(negedge clk); chk("t1_rd_c0", bus.f0_rd_en, 0);
        @(negedge clk); chk("t1_rd_c1", bus.f0_rd_en, 0); chk("t1_grant_c1", bus.grant, 2'b01);
        @(negedge clk); chk("t1_rd_c2", bus.f0_rd_en, 1);
        @(negedge clk); chk("t1_start_c3", bus.tx_start, 1);
        chk("t1_data", bus.tx_data, 8'hA5); chk("t1_grant", bus.grant, 2'b01);
        step(); man_done = 1;
        step(); man_done = 0;
        @(negedge clk);
        chk("t1_idle_grant", bus.grant, 0); chk("t1_idle_active", bus.active, 0);
        chk("t1_burst_cnt", bus.burst_cnt, 1);

        // Reset in WAIT (ch1 granted while pointer favours ch1), then in LOAD
        step();
        bus.en = 0;
        push1(8'h11); push1(8'h22); push1(8'h33);
        step();
        bus.en = 1;
        repeat (4) step();
        r1_save = rd1;
        push0(8'h44); push0(8'h55);
        rst = 1;
        step();
        rst = 0;
        @(negedge clk);
        chk_reset_outputs("rst_wait");
        chk("rst_wait_no_pop", rd1, r1_save);
        @(negedge clk);
        chk("rst_rr_restart", bus.grant, 2'b01);
        step();
        rst = 1;
        r0_save = rd0;
        @(negedge clk);
        chk("rst_load_rd_gated", bus.f0_rd_en, 0);
        step();
        rst = 0;
        @(negedge clk);
        chk_reset_outputs("rst_load");
        chk("rst_load_no_pop", rd0, r0_save);
        auto_tx = 1;
        wait_idle("rst_drain");
        chk("rst_drain_f0", rd0, wr0);
        chk("rst_drain_f1", rd1, wr1);

        // tx_busy held high in SEND
        auto_tx = 0;
        bus.en = 0;
        hold_busy = 1;
        push0(8'h3C);
        step();
        bus.en = 1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.f0_rd_en) begin seen = 1; break; end
        end
        chk("busy_load_seen", seen, 1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.tx_start || bus.tx_data != 8'h3C) bad++;
        end
        chk("busy_hold", bad, 0);
        step();
        hold_busy = 0;
        @(negedge clk); chk("busy_release_start", bus.tx_start, 1); chk("busy_data", bus.tx_data, 8'h3C);
        @(negedge clk); chk("busy_single_pulse", bus.tx_start, 0);
        step(); man_done = 1;
        step(); man_done = 0;
        wait_idle("busy_idle");

        // en dropped during WAIT of byte 2
        bus.en = 0;
        for (int i = 1; i <= 5; i++) push0(WIDTH'(i));
        step();
        r0_save = rd0;
        bus.en = 1;
        wait_start("endrop_b1");
        step(); man_done = 1;
        step(); man_done = 0;
        wait_start("endrop_b2");
        step();
        bus.en = 0;
        step(); step();
        man_done = 1;
        step();
        man_done = 0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.f0_rd_en || bus.f1_rd_en) bad++;
        end
        chk("endrop_no_pop", bad, 0);
        chk("endrop_idle", bus.active, 0);
        chk("endrop_burst_cnt", bus.burst_cnt, 2);
        chk("endrop_pops", rd0 - r0_save, 2);
        step();
        bus.en = 1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.f0_rd_en) begin seen = 1; break; end
        end
        chk("endrop_resume", seen, 1);
        auto_tx = 1;
        wait_idle("endrop_drain");
        bus.en = 0;
        step();
        wr0 = rd0;
        wr1 = rd1;

        // Known pointer state for the model
        rst = 1;
        step(); step();
        rst = 0;
        model_ptr = 0;

        vt[0] = '{1'b1, 2'b11, 10, 10, 2'b01, 10, 10};
        vt[1] = '{1'b1, 2'b10,  3,  2, 2'b10,  0,  2};
        vt[2] = '{1'b1, 2'b01,  5,  4, 2'b01,  5,  0};
        vt[3] = '{1'b0, 2'b11,  2,  2, 2'b00,  0,  0};
        vt[4] = '{1'b1, 2'b00,  2,  2, 2'b00,  0,  0};
        vt[5] = '{1'b1, 2'b11,  1,  3, 2'b10,  1,  3};
        for (int v = 0; v < 6; v++) begin
            run_vector(vt[v].en, vt[v].ch_en, vt[v].n0, vt[v].n1);
            chk($sformatf("vec%0d_first_grant", v), first_grant, vt[v].exp_first);
            chk($sformatf("vec%0d_pops0", v), pops0, vt[v].exp_pops0);
            chk($sformatf("vec%0d_pops1", v), pops1, vt[v].exp_pops1);
        end

        for (int r = 0; r < 8; r++) begin
            m_rand  = $urandom_range(1, 3);
            n0_rand = $urandom_range(0, 9);
            n1_rand = $urandom_range(0, 9);
            run_vector(1'b1, 2'(m_rand), n0_rand, n1_rand);
            chk($sformatf("rnd%0d_pops0", r), pops0, (m_rand & 1) ? n0_rand : 0);
            chk($sformatf("rnd%0d_pops1", r), pops1, (m_rand & 2) ? n1_rand : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between two byte FIFOs (channel 0 and channel 1).
- Arbitrates round-robin with a per-grant burst limit.
- Pops the FIFO, latches the byte, and sequences the transmitter start/done handshake.
- Sits between the TX-side FIFOs and the UART TX serializer.

Parameters:
WIDTH, 8, data width of FIFO words and tx_data
MAX_BURST, 4, max bytes sent per grant before re-arbitration (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
en  in  1  global enable; 0 = start no new byte
ch_en  in  2  per-channel enable mask, bit i = channel i
f0_empty  in  1  channel 0 FIFO empty flag
f0_data  in  WIDTH  channel 0 FIFO registered read data
f0_rd_en  out  1  channel 0 FIFO pop strobe
f1_empty  in  1  channel 1 FIFO empty flag
f1_data  in  WIDTH  channel 1 FIFO registered read data
f1_rd_en  out  1  channel 1 FIFO pop strobe
tx_busy  in  1  transmitter busy
tx_done  in  1  one-cycle pulse, byte finished on the line
tx_start  out  1  one-cycle start pulse to transmitter
tx_data  out  WIDTH  byte to transmit, held stable from tx_start until tx_done
grant  out  2  one-hot current owner, 00 when idle
active  out  1  1 whenever state != IDLE
burst_cnt  out  $clog2(MAX_BURST+1)  bytes completed in the current grant

Behaviour:
- Interface decisions:
  - Clock is clk; reset is rst, synchronous, active-high.
  - This block is the only reader of each FIFO.
  - FIFO read data is valid on the 2nd consecutive cycle of !empty after any pop. The SETTLE state guarantees this.
- Reset:
  - State = IDLE; grant = 00; tx_start = 0; f0_rd_en = f1_rd_en = 0; tx_data = 0; burst_cnt = 0; active = 0; rr pointer = channel 0.
  - Reset in any state aborts immediately. No pop or start is issued in the reset cycle.
- Eligibility: channel i is eligible when en && ch_en[i] && !fi_empty.
- States: IDLE, SETTLE, LOAD, SEND, WAIT.
- IDLE:
  - If any channel is eligible, pick one and go to SETTLE with grant set and burst_cnt = 0.
  - If both are eligible, pick the channel the rr pointer favours. Otherwise pick the single eligible channel.
- SETTLE: one cycle, no outputs; then LOAD.
- LOAD:
  - Assert the granted fi_rd_en for exactly one cycle.
  - Latch tx_data <= fi_data in the same cycle.
  - Go to SEND.
- SEND:
  - When tx_busy = 0, pulse tx_start for one cycle and go to WAIT.
  - While tx_busy = 1, hold in SEND with tx_start = 0.
- WAIT:
  - Hold until tx_done = 1, then increment burst_cnt.
  - If the new count < MAX_BURST and the granted channel is still eligible, go to SETTLE (same grant).
  - Otherwise go to IDLE, clear grant, and set the rr pointer to the other channel.
  - tx_done outside WAIT is ignored.
- Latency:
  - From IDLE with an eligible channel: rd_en in cycle +2, tx_start in cycle +3 (tx_busy = 0).
  - Back-to-back bytes in one grant: tx_done to next tx_start = 3 cycles.
- en or ch_en dropping mid-byte: the byte in flight completes through WAIT, then the block returns to IDLE. A popped byte is never discarded.
- Boundaries:
  - The granted FIFO cannot go empty between SETTLE and LOAD (sole reader).
  - rd_en is never asserted while that FIFO's empty = 1.
  - At most one rd_en is high per cycle.
  - grant is one-hot or zero at all times.
  - burst_cnt saturates at MAX_BURST and clears on the next grant.
- Fairness: with both channels continuously eligible, grants alternate, each for MAX_BURST bytes.

Test Plan:
- Reset, then f0 holds 1 byte 0xA5, tx_busy = 0 -> f0_rd_en high at cycle 2, tx_start at cycle 3 with tx_data = 0xA5, grant = 01. After tx_done: IDLE, grant = 00, burst_cnt = 1.
- f0 and f1 each hold 10 bytes, MAX_BURST = 4 -> transmit order: 4 from ch0, 4 from ch1, 4 from ch0, 4 from ch1, 2 from ch0, 2 from ch1. Data order preserved per channel.
- tx_busy held high for 20 cycles while in SEND -> tx_start stays 0, then pulses once in the cycle after tx_busy falls. tx_data stays stable throughout.
- ch_en = 10 with both FIFOs non-empty -> only f1_rd_en ever asserts. f0 is untouched.
- en cleared during WAIT of byte 2 of a burst -> byte 2 completes on tx_done, then IDLE. No further rd_en until en = 1.
- rst asserted in LOAD and in WAIT -> next cycle all outputs are at reset values. No extra pop occurs, and arbitration restarts from channel 0.
